// File: rtl/dsram_responder_pkg.sv
// Shared parameters and queue-entry layout for the data-SRAM responder.
// Defaults here are what the top and the bench pick up unless overridden.
package dsram_responder_pkg;

  localparam int unsigned RSP_LAT_DEF   = 2;
  localparam int unsigned RSP_DEPTH_DEF = 2;
  localparam int unsigned MEM_AW_DEF    = 10;
  localparam int unsigned CD_W          = 3;

  typedef struct packed {
    logic            is_wr;
    logic [31:0]     rdata;
    logic [CD_W-1:0] cd;
  } rsp_entry_t;

  localparam int unsigned ENTRY_W = $bits(rsp_entry_t);

endpackage

// File: rtl/dsram_responder_mem.sv
// Backing store: 2^AW x 32 synchronous RAM with byte write enables.
// Read data is registered on the same edge that samples the read address.
module dsram_mem #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:(1<<AW)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM slave model: accepts one request per cycle into an in-order
// response queue and answers each one RSP_LAT cycles after acceptance.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int unsigned RSP_LAT   = RSP_LAT_DEF,
  parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF,
  parameter int unsigned MEM_AW    = MEM_AW_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int unsigned     PW      = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PW:0]     DEPTH_C = (PW+1)'(RSP_DEPTH);
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(RSP_LAT - 1);

  rsp_entry_t           r_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] r_vld;
  logic [PW-1:0]        r_wptr, r_rptr, r_fill_ptr;
  logic [PW:0]          r_count;
  logic                 r_fill_pend;

  logic        w_accept, w_pop;
  logic [31:0] w_mem_q, w_rdata;
  rsp_entry_t  w_head;
  logic        w_unused;

  assign w_unused = ^{data_sram_size, data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0]};

  assign data_sram_addr_ok = (r_count < DEPTH_C);
  assign w_accept          = data_sram_req & data_sram_addr_ok & resetn;
  assign w_head            = r_q[r_rptr];
  assign data_sram_data_ok = resetn & r_vld[r_rptr] & (w_head.cd == '0);
  assign w_pop             = data_sram_data_ok;

  dsram_mem #(.AW(MEM_AW)) u_mem (
    .clk     (clk),
    .i_we    ({4{w_accept & data_sram_wr}} & data_sram_wstrb),
    .i_re    (w_accept & ~data_sram_wr),
    .i_addr  (data_sram_addr[MEM_AW+1:2]),
    .i_wdata (data_sram_wdata),
    .o_rdata (w_mem_q)
  );

  // Read data lands one cycle after acceptance; bypass it if already at the head.
  always_comb begin
    w_rdata = '0;
    if (data_sram_data_ok && !w_head.is_wr) begin
      if (r_fill_pend && (r_fill_ptr == r_rptr)) w_rdata = w_mem_q;
      else                                      w_rdata = w_head.rdata;
    end
  end

  assign data_sram_rdata = w_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fill_ptr  <= '0;
      r_count     <= '0;
      r_fill_pend <= 1'b0;
      r_vld       <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) r_q[i].cd <= '0;
    end else begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        if (r_vld[i] && (r_q[i].cd != '0)) r_q[i].cd <= r_q[i].cd - 1'b1;
      end
      if (r_fill_pend) r_q[r_fill_ptr].rdata <= w_mem_q;
      r_fill_pend <= w_accept & ~data_sram_wr;
      r_fill_ptr  <= r_wptr;
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      if (w_accept) begin
        r_q[r_wptr].is_wr <= data_sram_wr;
        r_q[r_wptr].rdata <= '0;
        r_q[r_wptr].cd    <= CD_INIT;
        r_vld[r_wptr]     <= 1'b1;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule
